// File: rtl/cacheline_adapter.sv
// Cache line <-> memory burst adapter: splits a line write into N beats and assembles N read beats into a line.
// Optional macro CACHELINE_ADAPTER_FAST_RESP_EN: respond on the final beat itself, skipping DONE.
module cacheline_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [31:0]        address_i,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int N  = s_line / s_burst;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] OFS_MASK = 32'(s_line / 8 - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                  state, state_n;
    logic [CW-1:0]               cnt;
    logic [31:0]                 addr;
    logic [N-1:0][s_burst-1:0]   rline, wline;
    logic                        busy, last_beat;

    assign busy      = (state == RD) || (state == WR);
    assign last_beat = busy && resp_i && (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (read_i)       state_n = RD;
                else if (write_i) state_n = WR;
            end
            RD, WR: begin
`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
                if (last_beat) state_n = IDLE;
`else
                if (last_beat) state_n = DONE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            rline <= '0;
            wline <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (read_i || write_i)) begin
                addr <= address_i;
                cnt  <= '0;
            end
            // write data is held separately so line_o only ever reflects read data
            if (state == IDLE && !read_i && write_i)
                wline <= line_i;
            if (busy && resp_i)
                cnt <= cnt + 1'b1;
            if (state == RD && resp_i)
                rline[cnt] <= burst_i;
        end
    end

    assign read_o    = (state == RD);
    assign write_o   = (state == WR);
    assign address_o = busy ? (addr & ~OFS_MASK) : 32'd0;
    assign burst_o   = (state == WR) ? wline[cnt] : '0;

`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
    logic [N-1:0][s_burst-1:0] line_fwd;
    assign resp_o = last_beat;
    always_comb begin
        line_fwd = rline;
        if (state == RD && last_beat)
            line_fwd[N-1] = burst_i;
    end
    assign line_o = line_fwd;
`else
    assign resp_o = (state == DONE);
    assign line_o = rline;
`endif

endmodule
